spi_slave_param: RTL

- Parametrised, fully synchronous SPI slave. It replaces the fixed 8-bit, mode-0-only SPI slave.
- ss, sclk and mosi are oversampled and synchronised into sys_clk. All state lives in the sys_clk domain.
- DATA_W, CPOL and CPHA are configurable. RX and TX each have a valid/ready handshake to the host-side logic.
- Sits between the external SPI pins and the register/command block.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave: FSM states,
// sclk edge-role selection from CPOL/CPHA, and bit-counter sizing.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Synced sclk level right after a sample edge: leading edge leaves CPOL,
  // trailing edge returns to it.
  function automatic logic sample_level(input logic cpol, input logic cpha);
    return cpha ? cpol : ~cpol;
  endfunction

  function automatic logic shift_level(input logic cpol, input logic cpha);
    return ~sample_level(cpol, cpha);
  endfunction

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with a toggle flag
// comparing the last two synced samples (rise = toggle & q, fall = toggle & ~q).
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // NOTE: non-blocking assignments, so each stage takes the previous stage's
  // old value and the chain really is SYNC_STAGES flops deep.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q      = sync[SYNC_STAGES-1];
  assign toggle = q ^ prev;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (DATA_W, CPOL, CPHA) fully inside sys_clk.
// Define SPI_SLAVE_PARAM_OVERRUN_EN to add sticky overrun/underrun flags.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy
`ifdef SPI_SLAVE_PARAM_OVERRUN_EN
  ,
  output logic              overrun,
  output logic              underrun
`endif
);

  localparam int   CNT_W      = cnt_width(DATA_W);
  localparam logic SAMPLE_LVL = sample_level(CPOL, CPHA);
  localparam logic SHIFT_LVL  = shift_level(CPOL, CPHA);

  logic ss_q, ss_tgl, sclk_q, sclk_tgl;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (ss),
    .q       (ss_q),
    .toggle  (ss_tgl)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (sclk),
    .q       (sclk_q),
    .toggle  (sclk_tgl)
  );

  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  always_ff @(posedge sys_clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic ss_rise, ss_fall, sample_edge, shift_edge;

  assign ss_rise     = ss_tgl & ss_q;
  assign ss_fall     = ss_tgl & ~ss_q;
  assign sample_edge = sclk_tgl & (sclk_q == SAMPLE_LVL);
  assign shift_edge  = sclk_tgl & (sclk_q == SHIFT_LVL);

  // After reset the chain holds stale zeros; only a low seen once the chain
  // has refilled arms the slave, so an ss held high through reset is ignored.
  logic [SYNC_STAGES:0] settle;
  logic                 armed;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      armed  <= armed | (settle[SYNC_STAGES] & ~ss_q);
    end
  end

  state_e             state, state_d;
  logic               load, sample_en, shift_en, complete, reload;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_last;
  logic [DATA_W-1:0]  shreg, hold_data;
  logic               hold_full, sample_bit, skip_shift;

  assign cnt_last = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    load      = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_rise && armed) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        sample_en = sample_edge;
        shift_en  = shift_edge;
        complete  = sample_edge && cnt_last;
        if (ss_fall) state_d = IDLE;
      end
    endcase
  end

  assign reload = load | complete;

  // A fresh word presents its MSB without shifting on the first shift edge:
  // for CPHA=1 that is the leading edge of bit 0, and after a word boundary it
  // is the trailing edge of the previous word's last bit.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shreg      <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      skip_shift <= 1'b0;
      sample_bit <= 1'b0;
      cnt_q      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      miso       <= 1'b0;
    end else begin
      if (reload) begin
        shreg      <= hold_full ? hold_data : '0;
        hold_full  <= 1'b0;
        skip_shift <= load ? CPHA : 1'b1;
      end else if (shift_en) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            shreg      <= {shreg[DATA_W-2:0], sample_bit};
      end

      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (load)           cnt_q <= '0;
      else if (sample_en) cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);

      if (sample_en) sample_bit <= mosi_s;

      if (complete) begin
        rx_data  <= {shreg[DATA_W-2:0], mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      miso <= (state == SHIFT) & shreg[DATA_W-1];
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == SHIFT);

`ifdef SPI_SLAVE_PARAM_OVERRUN_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (complete && rx_valid && !rx_ready) overrun  <= 1'b1;
      if (reload && !hold_full)              underrun <= 1'b1;
    end
  end
`endif

endmodule
